pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 50 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC operation codes
// and the link offset used for pc+4 / return addresses.
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        REG    = 3'd1,
        JUMP   = 3'd2,
        BRANCH = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } pc_ctrl_e;

    localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// a pop while empty is ignored (the caller reports that case).
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            full,
    output logic            empty
);
    import pc_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != DEPTH_C)
                count <= count + 1'b1;
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign top   = mem[wr_ptr - 1'b1];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: combinational next-PC mux around a single PC register.
// Define PC_SEQUENCER_RAS_EN to build in the return-address stack for CALL/RET.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [2:0]      pc_ctrl,
    input  logic [25:0]     jump_address,
    input  logic [15:0]     branch_offset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] reg_address,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] wdata,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            fault
);
    import pc_pkg::*;

    if (XLEN < 32 || XLEN > 64) begin : g_bad_xlen
        $error("pc_sequencer: XLEN out of range");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
    end

    localparam logic [XLEN-1:0] LINK = XLEN'(LINK_OFFSET);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            fault_q;
    logic            fault_next;
    logic [XLEN-1:0] link_addr;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] reg_target;
    logic [XLEN-1:0] branch_disp;

    assign link_addr   = pc_q + LINK;
    assign jump_target = {pc_q[XLEN-1:28], jump_address, 2'b00};
    assign reg_target  = {reg_address[XLEN-1:2], 2'b00};
    assign branch_disp = {{(XLEN-18){branch_offset[15]}}, branch_offset, 2'b00};

`ifdef PC_SEQUENCER_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_full_i;
    logic            ras_empty_i;
`endif

    always_comb begin
        pc_next    = link_addr;
        fault_next = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
`endif
        case (pc_ctrl)
            SEQ: pc_next = link_addr;
            REG: begin
                pc_next    = reg_target;
                fault_next = |reg_address[1:0];
            end
            JUMP: pc_next = jump_target;
            BRANCH: begin
                if (branch_taken)
                    pc_next = link_addr + branch_disp;
            end
            CALL: begin
                pc_next = jump_target;
`ifdef PC_SEQUENCER_RAS_EN
                ras_push = !stall;
`endif
            end
            RET: begin
`ifdef PC_SEQUENCER_RAS_EN
                // Underflow falls through to pc+4 and flags the error.
                if (ras_empty_i) begin
                    fault_next = 1'b1;
                end else begin
                    pc_next = ras_top;
                    ras_pop = !stall;
                end
`else
                pc_next    = reg_target;
                fault_next = |reg_address[1:0];
`endif
            end
            default: begin
                pc_next    = pc_q;
                fault_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else if (stall) begin
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            fault_q <= fault_next;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .full      (ras_full_i),
        .empty     (ras_empty_i)
    );

    assign ras_full  = ras_full_i;
    assign ras_empty = ras_empty_i;
`else
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
`endif

    assign pc    = pc_q;
    assign wdata = link_addr;
    assign fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_ctrl;
    logic [25:0] jump_address;
    logic [15:0] branch_offset;
    logic        branch_taken;
    logic [31:0] reg_address;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        ras_full;
    logic        ras_empty;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_stack[$];

    pc_sequencer #(
        .XLEN         (XLEN),
        .RAS_DEPTH    (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_ctrl       (pc_ctrl),
        .jump_address  (jump_address),
        .branch_offset (branch_offset),
        .branch_taken  (branch_taken),
        .reg_address   (reg_address),
        .pc            (pc),
        .wdata         (wdata),
        .ras_full      (ras_full),
        .ras_empty     (ras_empty),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_full, exp_empty;
`ifdef PC_SEQUENCER_RAS_EN
        exp_full  = (m_stack.size() == DEPTH);
        exp_empty = (m_stack.size() == 0);
`else
        exp_full  = 1'b0;
        exp_empty = 1'b1;
`endif
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_wdata"}, wdata, m_pc + 32'd4);
        check({tag, "_fault"}, {31'd0, fault}, {31'd0, m_fault});
        check({tag, "_full"}, {31'd0, ras_full}, {31'd0, exp_full});
        check({tag, "_empty"}, {31'd0, ras_empty}, {31'd0, exp_empty});
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_fault = 1'b0;
        m_stack.delete();
    endtask

    // Effect of one clock edge, written from the operation rules directly.
    task automatic model_edge(input logic [2:0] c, input logic [25:0] ja, input logic [15:0] bo,
                              input logic bt, input logic [31:0] ra, input logic st);
        logic [31:0] link, np;
        logic        f;
        int          off;
        if (st) begin
            m_fault = 1'b0;
            return;
        end
        link = m_pc + 32'd4;
        np   = link;
        f    = 1'b0;
        off  = int'($signed(bo));
        case (c)
            3'd0: np = link;
            3'd1: begin np = ra & 32'hFFFF_FFFC; f = (ra % 4) != 0; end
            3'd2: np = (m_pc & 32'hF000_0000) | (32'(ja) * 32'd4);
            3'd3: np = bt ? link + 32'(off * 4) : link;
            3'd4: begin
                np = (m_pc & 32'hF000_0000) | (32'(ja) * 32'd4);
`ifdef PC_SEQUENCER_RAS_EN
                m_stack.push_back(link);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
`endif
            end
            3'd5: begin
`ifdef PC_SEQUENCER_RAS_EN
                if (m_stack.size() == 0) begin np = link; f = 1'b1; end
                else np = m_stack.pop_back();
`else
                np = ra & 32'hFFFF_FFFC; f = (ra % 4) != 0;
`endif
            end
            default: begin np = m_pc; f = 1'b1; end
        endcase
        m_pc    = np;
        m_fault = f;
    endtask

    task automatic step(input string tag, input logic [2:0] c, input logic [25:0] ja,
                        input logic [15:0] bo, input logic bt, input logic [31:0] ra, input logic st);
        pc_ctrl       = c;
        jump_address  = ja;
        branch_offset = bo;
        branch_taken  = bt;
        reg_address   = ra;
        stall         = st;
        model_edge(c, ja, bo, bt, ra, st);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges: outputs must change without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_ctrl = 3'd0; jump_address = '0;
        branch_offset = '0; branch_taken = 1'b0; reg_address = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) step("seq", SEQ, '0, '0, 1'b0, '0, 1'b0);

        step("reg_setup", REG, '0, '0, 1'b0, 32'h1000_0010, 1'b0);
        step("jump", JUMP, 26'h000_0040, '0, 1'b0, '0, 1'b0);
        step("reg_100", REG, '0, '0, 1'b0, 32'h0000_0100, 1'b0);
        step("br_taken", BRANCH, '0, 16'hFFFC, 1'b1, '0, 1'b0);
        step("reg_100b", REG, '0, '0, 1'b0, 32'h0000_0100, 1'b0);
        step("br_not", BRANCH, '0, 16'hFFFC, 1'b0, '0, 1'b0);
        step("reg_mis", REG, '0, '0, 1'b0, 32'h0000_2002, 1'b0);
        step("fault_clr", SEQ, '0, '0, 1'b0, '0, 1'b0);

        step("to_10", REG, '0, '0, 1'b0, 32'h0000_0010, 1'b0);
        for (int k = 0; k < 5; k++) step("call", CALL, 26'(k + 2) * 26'd4, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) step("ret", RET, '0, '0, 1'b0, '0, 1'b0);
        step("ret_fclr", SEQ, '0, '0, 1'b0, '0, 1'b0);

        step("pre_call", CALL, 26'h100, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) step("stall_call", CALL, 26'h200, '0, 1'b0, '0, 1'b1);
        async_reset("rst_mid_stall");
        step("post_rst", SEQ, '0, '0, 1'b0, '0, 1'b0);

        step("to_top", REG, '0, '0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        step("wrap", SEQ, '0, '0, 1'b0, '0, 1'b0);
        step("code7", 3'd7, '0, '0, 1'b0, '0, 1'b0);
        step("code7_clr", SEQ, '0, '0, 1'b0, '0, 1'b0);
        step("code6", 3'd6, '0, '0, 1'b0, '0, 1'b0);
        step("code6_stall", SEQ, '0, '0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            step("rand", 3'($urandom_range(0, 7)), 26'($urandom), 16'($urandom),
                 1'($urandom), ra, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
